// File: rtl/wb_arbitre.sv
// ---------------------------------------------------------------------------
// wb_arbitre -- two-master Wishbone arbiter in front of a single slave port.
//
// Master 0 is the CPU-side port and master 1 is the video/stream reader. Both
// share one slave (the wb_bram port). Ownership is decided round-robin when
// both masters raise cyc together. Once a master owns the bus it keeps it for
// the whole cyc, so classic cycles and cti bursts are never split.
//
// An ack watchdog watches the owner's strobe. If the slave leaves a strobe
// unacknowledged for TIMEOUT consecutive cycles, the owner gets err for
// exactly one cycle. The grant is not revoked; the master is expected to
// drop cyc after seeing err.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   mX_cyc/stb/we     master X (X = 0,1) cycle, strobe, write enable
//   mX_adr/dat_ms     master X address and write data
//   mX_sel/cti/bte    master X byte selects, cycle type, burst type
//   mX_dat_sm         read data back to master X (shared slave data)
//   mX_ack/err        master X acknowledge / error
//   s_*               slave-side copy of the owner's bus signals
//   s_dat_sm, s_ack   slave read data and acknowledge
//   grant             one-hot current owner (01 = m0, 10 = m1), debug only
//
// Parameters:
//   ADR_W, DAT_W      address and data width (sel width is DAT_W/8)
//   TIMEOUT           stalled strobe cycles before err (>= 2)
//   CNT_W             watchdog counter width (2**CNT_W > TIMEOUT)
// ---------------------------------------------------------------------------
module wb_arbitre #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_ms,
  input  logic [DAT_W/8-1:0] m0_sel,
  input  logic [2:0]         m0_cti,
  input  logic [1:0]         m0_bte,
  output logic [DAT_W-1:0]   m0_dat_sm,
  output logic               m0_ack,
  output logic               m0_err,

  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_ms,
  input  logic [DAT_W/8-1:0] m1_sel,
  input  logic [2:0]         m1_cti,
  input  logic [1:0]         m1_bte,
  output logic [DAT_W-1:0]   m1_dat_sm,
  output logic               m1_ack,
  output logic               m1_err,

  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_ms,
  output logic [DAT_W/8-1:0] s_sel,
  output logic [2:0]         s_cti,
  output logic [1:0]         s_bte,
  input  logic [DAT_W-1:0]   s_dat_sm,
  input  logic               s_ack,

  output logic [1:0]         grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // Watchdog terminal value: the err fires on the cycle after the counter
  // has seen TIMEOUT stalled strobes (values 0 .. TIMEOUT-1).
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             rr_last;
  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  logic             own0;
  logic             own1;
  logic             own_stb;
  logic             leaving;
  logic             stall;

  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

  // Arbitration state machine. rr_last remembers the last master that
  // released the bus so that a simultaneous request from IDLE goes to the
  // other one; after reset it points at master 1 so master 0 wins the first
  // tie. An owner keeps the bus as long as its cyc is high. On release the
  // bus moves straight to a waiting master without passing through IDLE.
  // grant is registered alongside the state so the debug output is glitch
  // free and drops to 00 the moment reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      grant   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && m1_cyc) begin
            if (rr_last) begin
              state <= GNT0;
              grant <= 2'b01;
            end else begin
              state <= GNT1;
              grant <= 2'b10;
            end
          end else if (m0_cyc) begin
            state <= GNT0;
            grant <= 2'b01;
          end else if (m1_cyc) begin
            state <= GNT1;
            grant <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0_cyc) begin
            rr_last <= 1'b0;
            if (m1_cyc) begin
              state <= GNT1;
              grant <= 2'b10;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!m1_cyc) begin
            rr_last <= 1'b1;
            if (m0_cyc) begin
              state <= GNT0;
              grant <= 2'b01;
            end else begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Slave-side multiplexer, driven purely from the registered owner. In IDLE
  // the control strobes are held low and the remaining bus fields simply
  // follow master 0 so the slave sees stable values. The owner's strobe is
  // masked during the err cycle so the slave never starts a new access while
  // the master is being told its current one failed.
  always_comb begin
    s_cyc    = 1'b0;
    own_stb  = 1'b0;
    s_we     = 1'b0;
    s_adr    = m0_adr;
    s_dat_ms = m0_dat_ms;
    s_sel    = m0_sel;
    s_cti    = m0_cti;
    s_bte    = m0_bte;
    if (own0) begin
      s_cyc   = m0_cyc;
      own_stb = m0_stb;
      s_we    = m0_we;
    end else if (own1) begin
      s_cyc    = m1_cyc;
      own_stb  = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_ms = m1_dat_ms;
      s_sel    = m1_sel;
      s_cti    = m1_cti;
      s_bte    = m1_bte;
    end
  end

  assign s_stb = own_stb & ~err_q;

  // Responses back to the masters. Only the owner ever sees ack or err, and
  // an ack that happens to coincide with the err cycle is swallowed. Read
  // data is a shared wire; it only means something alongside the owner's ack.
  assign m0_ack    = own0 & s_ack & m0_stb & ~err_q;
  assign m1_ack    = own1 & s_ack & m1_stb & ~err_q;
  assign m0_err    = own0 & err_q;
  assign m1_err    = own1 & err_q;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  // A stall is a strobe the slave is currently not acknowledging. leaving
  // flags the cycle on which the owner lets go of the bus, because the count
  // belongs to a single grant and must not carry over to the next owner.
  assign stall   = s_stb & ~s_ack;
  assign leaving = (own0 & ~m0_cyc) | (own1 & ~m1_cyc);

  // Ack watchdog. The counter advances on every stalled strobe of the same
  // grant and clears on ack, on strobe low and on an ownership change. When
  // the terminal value is reached without an ack, err_q pulses for one cycle
  // and the count restarts from zero. An ack on the terminal cycle removes
  // the stall, so ack takes priority over err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (stall && (wd_cnt == WD_LAST)) begin
      wd_cnt <= '0;
      err_q  <= 1'b1;
    end else begin
      err_q <= 1'b0;
      if (stall && !leaving) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbitre.sv
// ---------------------------------------------------------------------------
// tb_wb_arbitre -- self-checking bench for the two-master Wishbone arbiter.
//
// A small slave memory answers the arbiter's slave port with a selectable
// ack policy (always, random, never). Every cycle the bench predicts the
// arbiter's outputs from an ownership model (who holds the bus, who released
// last, how long the current strobe has stalled) and a data scoreboard that
// tracks what each acknowledged write stored. Directed steps cover the
// single-master, contention, burst-lock, watchdog and async-reset scenarios;
// a randomized phase with two autonomous masters follows.
// ---------------------------------------------------------------------------
module tb_wb_arbitre;

  localparam int ADR_W   = 32;
  localparam int DAT_W   = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic [2:0]  m0_cti;
  logic [1:0]  m0_bte;
  logic        m0_ack, m0_err;

  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic [2:0]  m1_cti;
  logic [1:0]  m1_bte;
  logic        m1_ack, m1_err;

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [31:0] s_dat_sm = '0;
  logic        s_ack = 1'b0;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 = none), last releaser, stall count
  // of the current grant and whether this cycle is an err cycle.
  int          m_owner;
  int          m_last;
  int          m_stall;
  bit          m_err;
  logic [31:0] exp_mem   [16];
  logic [31:0] slave_mem [16];
  int          ack_mode;

  // Observations of the last cycle, used by the masters to react.
  bit          seen_ack [2];
  bit          seen_err [2];
  logic [1:0]  last_grant;
  logic [31:0] last_sadr;
  logic        last_sstb;
  logic [31:0] last_dat0;

  // Random master state.
  bit          rc_cyc [2];
  bit          rc_stb [2];
  bit          rc_we  [2];
  logic [3:0]  rc_idx [2];
  logic [31:0] rc_dat [2];
  logic [2:0]  rc_cti [2];
  logic [3:0]  rc_sel [2];
  logic [1:0]  rc_bte [2];

  always #5 clk = ~clk;

  wb_arbitre #(
    .ADR_W   (ADR_W),
    .DAT_W   (DAT_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_dat_ms (m0_dat_ms),
    .m0_sel    (m0_sel),
    .m0_cti    (m0_cti),
    .m0_bte    (m0_bte),
    .m0_dat_sm (m0_dat_sm),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_dat_ms (m1_dat_ms),
    .m1_sel    (m1_sel),
    .m1_cti    (m1_cti),
    .m1_bte    (m1_bte),
    .m1_dat_sm (m1_dat_sm),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_cti     (s_cti),
    .s_bte     (s_bte),
    .s_dat_sm  (s_dat_sm),
    .s_ack     (s_ack),
    .grant     (grant)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one master's request lines.
  task automatic applyStimulus(input int x, input bit cyc, input bit stb, input bit we,
                               input logic [31:0] adr, input logic [31:0] dat,
                               input logic [2:0] cti, input logic [3:0] sel = 4'hF,
                               input logic [1:0] bte = 2'b00);
    if (x == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr;
      m0_dat_ms = dat; m0_cti = cti; m0_sel = sel; m0_bte = bte;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr;
      m1_dat_ms = dat; m1_cti = cti; m1_sel = sel; m1_bte = bte;
    end
  endtask

  task automatic clearMasters();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  function automatic bit mcyc(input int x);
    return (x == 1) ? m1_cyc : m0_cyc;
  endfunction

  task automatic modelReset();
    m_owner = -1;
    m_last  = 1;
    m_stall = 0;
    m_err   = 1'b0;
  endtask

  // Assert reset with a live request and a high slave ack; nothing may leak out.
  task automatic doReset();
    rst_n = 1'b0;
    clearMasters();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
    s_ack = 1'b1;
    #1;
    checkOutput("rst_grant", {30'd0, grant}, 32'd0);
    checkOutput("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("rst_s_stb", {31'd0, s_stb}, 32'd0);
    checkOutput("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    checkOutput("rst_m0_err", {31'd0, m0_err}, 32'd0);
    checkOutput("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    clearMasters();
    s_ack = 1'b0;
    rst_n = 1'b1;
  endtask

  // One bus cycle. Called at a falling edge with the master inputs already
  // driven: the slave answers, every output is compared with the model, then
  // the rising edge commits writes and advances the model.
  task automatic tick();
    logic [1:0]  e_grant;
    logic        e_cyc, e_stb, e_we;
    logic        e_ack0, e_ack1, e_err0, e_err1;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte;
    logic        sw, ew;
    logic [3:0]  sw_idx, ew_idx;
    logic [31:0] sw_dat, ew_dat;
    logic        stall_now;
    int          nxt;

    #1;
    case (ack_mode)
      0:       s_ack = s_stb;
      1:       s_ack = 1'($urandom_range(0, 1));
      default: s_ack = 1'b0;
    endcase
    s_dat_sm = slave_mem[s_adr[5:2]];
    #1;

    e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    e_cyc   = (m_owner == 0) ? m0_cyc : (m_owner == 1) ? m1_cyc : 1'b0;
    e_stb   = ((m_owner == 0) ? m0_stb : (m_owner == 1) ? m1_stb : 1'b0) & ~m_err;
    e_we    = (m_owner == 0) ? m0_we : (m_owner == 1) ? m1_we : 1'b0;
    e_adr   = (m_owner == 1) ? m1_adr : m0_adr;
    e_dat   = (m_owner == 1) ? m1_dat_ms : m0_dat_ms;
    e_sel   = (m_owner == 1) ? m1_sel : m0_sel;
    e_cti   = (m_owner == 1) ? m1_cti : m0_cti;
    e_bte   = (m_owner == 1) ? m1_bte : m0_bte;
    e_ack0  = (m_owner == 0) && s_ack && m0_stb && !m_err;
    e_ack1  = (m_owner == 1) && s_ack && m1_stb && !m_err;
    e_err0  = (m_owner == 0) && m_err;
    e_err1  = (m_owner == 1) && m_err;

    checkOutput("grant", {30'd0, grant}, {30'd0, e_grant});
    checkOutput("s_cyc", {31'd0, s_cyc}, {31'd0, e_cyc});
    checkOutput("s_stb", {31'd0, s_stb}, {31'd0, e_stb});
    checkOutput("s_we", {31'd0, s_we}, {31'd0, e_we});
    checkOutput("s_adr", s_adr, e_adr);
    checkOutput("s_dat_ms", s_dat_ms, e_dat);
    checkOutput("s_sel", {28'd0, s_sel}, {28'd0, e_sel});
    checkOutput("s_cti", {29'd0, s_cti}, {29'd0, e_cti});
    checkOutput("s_bte", {30'd0, s_bte}, {30'd0, e_bte});
    checkOutput("m0_ack", {31'd0, m0_ack}, {31'd0, e_ack0});
    checkOutput("m1_ack", {31'd0, m1_ack}, {31'd0, e_ack1});
    checkOutput("m0_err", {31'd0, m0_err}, {31'd0, e_err0});
    checkOutput("m1_err", {31'd0, m1_err}, {31'd0, e_err1});
    if (e_ack0 && !m0_we) checkOutput("m0_rdata", m0_dat_sm, exp_mem[m0_adr[5:2]]);
    if (e_ack1 && !m1_we) checkOutput("m1_rdata", m1_dat_sm, exp_mem[m1_adr[5:2]]);

    seen_ack[0] = m0_ack;
    seen_ack[1] = m1_ack;
    seen_err[0] = m0_err;
    seen_err[1] = m1_err;
    last_grant  = grant;
    last_sadr   = s_adr;
    last_sstb   = s_stb;
    last_dat0   = m0_dat_sm;

    sw     = s_cyc && s_stb && s_we && s_ack;
    sw_idx = s_adr[5:2];
    sw_dat = s_dat_ms;
    ew     = 1'b0;
    ew_idx = '0;
    ew_dat = '0;
    if (e_ack0 && m0_we) begin
      ew = 1'b1; ew_idx = m0_adr[5:2]; ew_dat = m0_dat_ms;
    end else if (e_ack1 && m1_we) begin
      ew = 1'b1; ew_idx = m1_adr[5:2]; ew_dat = m1_dat_ms;
    end

    @(posedge clk);
    if (sw) slave_mem[sw_idx] = sw_dat;
    if (ew) exp_mem[ew_idx] = ew_dat;

    stall_now = e_stb && !s_ack;
    if (m_owner < 0) begin
      if (m0_cyc && m1_cyc) nxt = (m_last == 1) ? 0 : 1;
      else if (m0_cyc)      nxt = 0;
      else if (m1_cyc)      nxt = 1;
      else                  nxt = -1;
    end else if (!mcyc(m_owner)) begin
      m_last = m_owner;
      nxt    = mcyc(1 - m_owner) ? (1 - m_owner) : -1;
    end else begin
      nxt = m_owner;
    end
    if (stall_now && (m_stall == TIMEOUT - 1)) begin
      m_err   = 1'b1;
      m_stall = 0;
    end else begin
      m_err   = 1'b0;
      m_stall = (stall_now && nxt == m_owner) ? m_stall + 1 : 0;
    end
    m_owner = nxt;
    @(negedge clk);
  endtask

  task automatic newBeat(input int x);
    rc_we[x]  = 1'($urandom_range(0, 1));
    rc_idx[x] = 4'($urandom_range(0, 15));
    rc_dat[x] = $urandom;
    rc_sel[x] = 4'($urandom_range(0, 15));
    rc_bte[x] = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 2))
      0:       rc_cti[x] = 3'b000;
      1:       rc_cti[x] = 3'b010;
      default: rc_cti[x] = 3'b111;
    endcase
  endtask

  // Autonomous master: opens cycles at random, holds stb until ack, may run
  // several beats per cycle, and abandons the cycle on err.
  task automatic randomMaster(input int x);
    if (!rc_cyc[x]) begin
      if ($urandom_range(0, 3) == 0) begin
        rc_cyc[x] = 1'b1;
        rc_stb[x] = 1'b1;
        newBeat(x);
      end
    end else if (seen_err[x]) begin
      rc_cyc[x] = 1'b0;
      rc_stb[x] = 1'b0;
    end else if (seen_ack[x]) begin
      if ($urandom_range(0, 2) == 0) begin
        rc_cyc[x] = 1'b0;
        rc_stb[x] = 1'b0;
      end else begin
        rc_stb[x] = ($urandom_range(0, 3) != 0);
        newBeat(x);
      end
    end else if (!rc_stb[x]) begin
      rc_stb[x] = 1'($urandom_range(0, 1));
    end
    applyStimulus(x, rc_cyc[x], rc_stb[x], rc_we[x], {26'd0, rc_idx[x], 2'b00},
                  rc_dat[x], rc_cti[x], rc_sel[x], rc_bte[x]);
  endtask

  initial begin
    int ack_count;
    int err_early;

    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 32'h0101_0101 * i;
      exp_mem[i]   = 32'h0101_0101 * i;
    end
    ack_mode = 0;
    clearMasters();
    #1;

    // Reset state.
    doReset();

    // Single master: write then read 0xDEADBEEF at 0x10.
    ack_mode = 0;
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'b000);
    tick();
    checkOutput("b_lat_noack", {31'd0, seen_ack[0]}, 32'd0);
    tick();
    checkOutput("b_wr_ack", {31'd0, seen_ack[0]}, 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 3'b000);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
    tick();
    tick();
    checkOutput("b_rd_ack", {31'd0, seen_ack[0]}, 32'd1);
    checkOutput("b_rd_data", last_dat0, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();

    // Contention from reset, four rounds: m0 first, direct hand-off to m1.
    doReset();
    for (int r = 0; r < 4; r++) begin
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'(r * 8), 32'h0, 3'b000);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'(r * 8 + 4), 32'h0, 3'b000);
      tick();
      tick();
      checkOutput($sformatf("c%0d_first", r), {30'd0, last_grant}, 32'd1);
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      tick();
      checkOutput($sformatf("c%0d_handoff", r), {30'd0, last_grant}, 32'd2);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
      tick();
      tick();
      checkOutput($sformatf("c%0d_idle", r), {30'd0, last_grant}, 32'd0);
    end

    // Burst lock: 4-beat m1 burst, m0 requests at beat 2.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    tick();
    for (int beat = 0; beat < 4; beat++) begin
      if (beat > 0)
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h20 + 32'(4 * beat), 32'h0,
                      (beat == 3) ? 3'b111 : 3'b010);
      if (beat == 2)
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
      tick();
      checkOutput($sformatf("d_ack%0d", beat), {31'd0, seen_ack[1]}, 32'd1);
      checkOutput($sformatf("d_adr%0d", beat), last_sadr, 32'h20 + 32'(4 * beat));
      checkOutput($sformatf("d_grant%0d", beat), {30'd0, last_grant}, 32'd2);
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput("d_m0_wait", {31'd0, seen_ack[0]}, 32'd0);
    tick();
    checkOutput("d_m0_grant", {30'd0, last_grant}, 32'd1);
    checkOutput("d_m0_ack", {31'd0, seen_ack[0]}, 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();

    // Watchdog: no slave ack; m0 drops cyc on the err cycle with m1 waiting.
    ack_mode = 2;
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 3'b000);
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h38, 32'h0, 3'b000);
    ack_count = 0;
    err_early = 0;
    repeat (TIMEOUT) begin
      tick();
      ack_count += int'(seen_ack[0]);
      err_early += int'(seen_err[0]);
    end
    checkOutput("e_noack", 32'(ack_count), 32'd0);
    checkOutput("e_no_early_err", 32'(err_early), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    checkOutput("e_err", {31'd0, seen_err[0]}, 32'd1);
    checkOutput("e_sstb", {31'd0, last_sstb}, 32'd0);
    checkOutput("e_err_grant", {30'd0, last_grant}, 32'd1);
    ack_mode = 0;
    tick();
    checkOutput("e_handoff", {30'd0, last_grant}, 32'd2);
    checkOutput("e_err_once", {31'd0, seen_err[0]}, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();

    // Ack arriving on the watchdog terminal cycle wins over err.
    ack_mode = 2;
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h34, 32'h0, 3'b000);
    tick();
    repeat (TIMEOUT - 1) tick();
    ack_mode = 0;
    tick();
    checkOutput("f_ack", {31'd0, seen_ack[1]}, 32'd1);
    checkOutput("f_ack_noerr", {31'd0, seen_err[1]}, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h34, 32'h0, 3'b000);
    tick();
    checkOutput("f_noerr", {31'd0, seen_err[1]}, 32'd0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();

    // Async reset between edges while m1 owns a burst.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 3'b010);
    tick();
    tick();
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h54, 32'h0, 3'b010);
    #2;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    checkOutput("g_grant", {30'd0, grant}, 32'd0);
    checkOutput("g_s_cyc", {31'd0, s_cyc}, 32'd0);
    checkOutput("g_m1_ack", {31'd0, m1_ack}, 32'd0);
    checkOutput("g_m1_err", {31'd0, m1_err}, 32'd0);
    clearMasters();
    modelReset();
    @(posedge clk);
    @(negedge clk);
    s_ack = 1'b0;
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h58, 32'h0, 3'b000);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h5C, 32'h0, 3'b000);
    tick();
    tick();
    checkOutput("g_first", {30'd0, last_grant}, 32'd1);
    clearMasters();
    tick();

    // Randomized traffic from two autonomous masters.
    for (int x = 0; x < 2; x++) begin
      rc_cyc[x]   = 1'b0;
      rc_stb[x]   = 1'b0;
      seen_ack[x] = 1'b0;
      seen_err[x] = 1'b0;
      newBeat(x);
    end
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: ack_mode = 1;
        4, 5, 6:    ack_mode = 0;
        default:    ack_mode = 2;
      endcase
      repeat (50) begin
        randomMaster(0);
        randomMaster(1);
        tick();
      end
    end
    clearMasters();
    ack_mode = 0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbitre.md
Name: wb_arbitre

Overview:
- Two-master Wishbone arbiter. It shares the single wb_bram slave port between master 0 (CPU-side) and master 1 (video/stream reader).
- Round-robin grant with cycle locking: a grant is held for the whole cyc, so classic cycles and cti bursts (incrementing and constant-address) are never split.
- Per-grant ack watchdog returns err to a master whose strobe goes unacknowledged, so a faulty slave path cannot deadlock the bus.

Parameters:
- ADR_W, 32, address width on all ports.
- DAT_W, 32, data width; sel width is DAT_W/8.
- TIMEOUT, 255, number of consecutive unacknowledged strobe cycles before err. Must be ≥ 2.
- CNT_W, 8, watchdog counter width. Must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- mX_cyc, mX_stb, mX_we  in  1 each  master X (X=0,1) cycle, strobe, write enable.
- mX_adr  in  ADR_W  master X address.
- mX_dat_ms  in  DAT_W  master X write data.
- mX_sel  in  DAT_W/8  master X byte selects.
- mX_cti  in  3  master X cycle type.
- mX_bte  in  2  master X burst type.
- mX_dat_sm  out  DAT_W  read data to master X.
- mX_ack, mX_err  out  1 each  master X acknowledge, error.
- s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe, write enable.
- s_adr  out  ADR_W  slave address.
- s_dat_ms  out  DAT_W  slave write data.
- s_sel  out  DAT_W/8  slave byte selects.
- s_cti  out  3  slave cycle type.
- s_bte  out  2  slave burst type.
- s_dat_sm  in  DAT_W  slave read data.
- s_ack  in  1  slave acknowledge.
- grant  out  2  one-hot current owner (debug).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, rr_last=1 (master 0 wins first tie), wd_cnt=0, err_q=0.
  - All outputs during reset: grant=00, s_cyc=s_stb=0, mX_ack=mX_err=0.
  - Reset mid-cycle aborts the transfer silently; no ack or err is issued.
- State machine states: IDLE, GNT0, GNT1, all registered.
  - IDLE: if only mX_cyc=1, go to GNTX. If both are 1, grant the master ≠ rr_last. Otherwise stay in IDLE. Arbitration latency is 1 clk.
  - GNTX while mX_cyc=1: stay. The other master's requests are ignored; there is no preemption, including mid-burst.
  - GNTX when mX_cyc=0: if the other master's cyc=1, go directly to GNTother (no IDLE bubble), else go to IDLE. rr_last<=X on every exit from GNTX.
- Mux rules (combinational from registered state):
  - In GNTX, all s_* outputs follow master X.
  - s_cyc = mX_cyc.
  - s_stb = mX_stb & ~err_q.
  - mX_ack = s_ack & mX_stb & ~err_q.
  - Non-owner: ack=0 and err=0.
  - In IDLE: s_cyc=s_stb=s_we=0; other s_* outputs are don't-care but held from master 0.
  - mX_dat_sm = s_dat_sm for both masters (shared bus); it is only valid with the owner's ack.
- Watchdog:
  - wd_cnt increments on each clk where the state is GNTX, s_stb=1 and s_ack=0.
  - It clears on s_ack, on state change, and on stb=0.
  - When wd_cnt==TIMEOUT-1 and no ack arrives, err_q<=1 for exactly one cycle. mX_err=err_q for the owner.
  - During the err_q cycle, s_stb and mX_ack are forced to 0. wd_cnt then restarts from 0.
  - The grant is kept; the master must drop cyc.
- Simultaneous events:
  - Owner drops cyc in the same cycle err_q rises: err is still presented that cycle and the grant transfers next cycle.
  - s_ack together with the watchdog terminal count: ack wins, no err.
- Burst transparency: cti/bte pass through unchanged. End-of-burst (cti=111) needs no special handling beyond the cyc release rule.

Test Plan:
- Single master: m0 performs a classic write then a read of 0xDEADBEEF at adr 0x10. Required: 1-clk grant latency, then m0_ack mirrors s_ack, read data matches, m1_ack stays 0 throughout.
- Contention from reset: m0_cyc and m1_cyc rise in the same clk. Required: GNT0 first; after m0 drops cyc, GNT1 on the next clk with no IDLE cycle. Next simultaneous request: GNT1 is not repeated and m0 wins (alternation over 4 rounds).
- Burst lock: m1 performs a 4-beat incrementing burst (cti=010, last beat 111) while m0 requests at beat 2. Required: s_adr shows m1's addresses for all 4 acks and m0 is granted only after m1_cyc=0.
- Watchdog: slave ack tied low, m0 strobes. Required: m0_err=1 for exactly 1 clk after TIMEOUT stalled cycles (test with TIMEOUT=8), s_stb=0 that clk, no m0_ack.
- Async reset mid-burst: rst_n pulled low between clock edges during GNT1. Required: grant=00 and s_cyc=0 immediately without waiting for a clock edge; after release, a first simultaneous request goes to m0.
